// File: rtl/spi_mpu_burst_if.sv
// spi_mpu_burst_if
// Purpose: groups the request/result bus and the SPI pin signals of spi_mpu_burst.
// Build option: SPI_MPU_BURST_CS_EN adds the active-low chip select ncs.
// Signals:
//   start, rw, addr, len, wdata : request from the polling sequencer
//   busy, finish                : frame status
//   rdata, byte_valid, byte_idx : read results, with one strobe per completed byte
//   sclk, mosi, miso            : SPI mode 3 pins (ncs too when enabled)
//   dbg_state                   : FSM state of the master, for observation only
// Modports:
//   slave  : the SPI master block (spi_mpu_burst)
//   master : the sequencer / sensor side
// Handshake: start is a one-cycle request. It is taken only while the block is
//   idle, which includes the finish cycle. busy is high from the edge that
//   accepts start up to, but not including, the finish cycle. A start seen while
//   busy is dropped and is not queued.
interface spi_mpu_burst_if #(
    parameter int MAX_BYTES = 14
);
    localparam int LEN_W = $clog2(MAX_BYTES + 1);

    logic                   start;
    logic                   rw;
    logic [6:0]             addr;
    logic [LEN_W-1:0]       len;
    logic [8*MAX_BYTES-1:0] wdata;
    logic                   miso;
    logic                   sclk;
    logic                   mosi;
    logic                   busy;
    logic                   finish;
    logic [8*MAX_BYTES-1:0] rdata;
    logic                   byte_valid;
    logic [LEN_W-1:0]       byte_idx;
    logic [1:0]             dbg_state;
`ifdef SPI_MPU_BURST_CS_EN
    logic                   ncs;

    modport slave (
        input  start, rw, addr, len, wdata, miso,
        output sclk, mosi, busy, finish, rdata, byte_valid, byte_idx, dbg_state, ncs
    );
    modport master (
        output start, rw, addr, len, wdata, miso,
        input  sclk, mosi, busy, finish, rdata, byte_valid, byte_idx, dbg_state, ncs
    );
`else
    modport slave (
        input  start, rw, addr, len, wdata, miso,
        output sclk, mosi, busy, finish, rdata, byte_valid, byte_idx, dbg_state
    );
    modport master (
        output start, rw, addr, len, wdata, miso,
        input  sclk, mosi, busy, finish, rdata, byte_valid, byte_idx, dbg_state
    );
`endif
endinterface

// File: rtl/spi_mpu_burst.sv
// spi_mpu_burst
// Purpose: SPI mode 3 (CPOL=1, CPHA=1) master for MPU9250-class sensors. Each
//   frame sends a command byte {rw, addr} and then 1..MAX_BYTES data bytes, MSB
//   first. Read frames collect data bytes into rdata and raise a strobe for each
//   completed byte. Write frames send the wdata bytes.
// Build option: SPI_MPU_BURST_CS_EN adds the registered active-low chip select ncs.
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   bus   : spi_mpu_burst_if.slave (request, status, read results, SPI pins)
// Parameters:
//   SCLK_HALF   : system clocks per sclk half-period (>=2)
//   HOLD_CYCLES : idle-high sclk cycles after the last bit, before finish (>=1)
//   MAX_BYTES   : largest burst length in data bytes (>=1)
module spi_mpu_burst #(
    parameter int SCLK_HALF   = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_BYTES   = 14
) (
    input logic            clk,
    input logic            rst_n,
    spi_mpu_burst_if.slave bus
);
    localparam int LEN_W   = $clog2(MAX_BYTES + 1);
    localparam int FRAME_W = 8 * (MAX_BYTES + 1);
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int IDX_W   = BIT_W - 3;
    localparam int CNT_MAX = (2 * SCLK_HALF > HOLD_CYCLES) ? 2 * SCLK_HALF : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RISE_CNT  = CNT_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;        // cycle count within SETUP/HOLD, or the bit phase in SHIFT
    logic [BIT_W-1:0]     bit_cnt;    // index of the frame bit now on the wire
    logic [BIT_W-1:0]     frame_bits;
    logic                 rw_q;
    logic [FRAME_W-1:0]   tx_sr;
    logic [6:0]           rx_sr;
    logic                 sclk_q, mosi_q, busy_q, finish_q, bv_q;
    logic [8*MAX_BYTES-1:0] rdata_q;
    logic [LEN_W-1:0]     idx_q;

    logic [LEN_W-1:0]     n_eff;
    logic [BIT_W-1:0]     frame_bits_d;
    logic [FRAME_W-1:0]   tx_load;
    logic                 last_bit;
    logic [IDX_W-1:0]     byte_num;
    logic                 data_byte_end;

    // len 0 is treated as 1, and anything above MAX_BYTES is clamped.
    always_comb begin
        n_eff = bus.len;
        if (bus.len == '0) begin
            n_eff = LEN_W'(1);
        end else if (bus.len > LEN_MAX) begin
            n_eff = LEN_MAX;
        end
    end

    assign frame_bits_d = BIT_W'({n_eff, 3'b000}) + BIT_W'(8);

    // The whole frame is left-aligned: command first, then byte 0, byte 1, ...
    // A read sends zeros after the command byte.
    always_comb begin
        tx_load = '0;
        tx_load[FRAME_W-1 -: 8] = {bus.rw, bus.addr};
        if (!bus.rw) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
                tx_load[FRAME_W-9-8*k -: 8] = bus.wdata[8*k +: 8];
            end
        end
    end

    assign last_bit      = (bit_cnt == frame_bits - BIT_W'(1));
    // Byte 0 of the data follows the command byte, so the data index is one
    // less than the frame byte index.
    assign byte_num      = bit_cnt[BIT_W-1:3] - IDX_W'(1);
    assign data_byte_end = (bit_cnt[BIT_W-1:3] != '0) && (bit_cnt[2:0] == 3'd7);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SETUP;
            SETUP:   if (cnt == RISE_CNT) state_next = SHIFT;
            SHIFT:   if (cnt == BIT_LAST && last_bit) state_next = HOLD;
            HOLD:    if (cnt == HOLD_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            frame_bits <= '0;
            rw_q       <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            sclk_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            bv_q       <= 1'b0;
            rdata_q    <= '0;
            idx_q      <= '0;
        end else begin
            finish_q <= 1'b0;
            bv_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt        <= '0;
                        bit_cnt    <= '0;
                        frame_bits <= frame_bits_d;
                        rw_q       <= bus.rw;
                        tx_sr      <= tx_load;
                        mosi_q     <= bus.rw;   // command MSB is already on mosi during SETUP
                        rdata_q    <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == RISE_CNT) begin
                        cnt    <= '0;
                        sclk_q <= 1'b0;
                        mosi_q <= tx_sr[FRAME_W-1];
                        tx_sr  <= tx_sr << 1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (cnt == RISE_CNT) begin
                        // Rising edge: the sensor changed miso on the falling edge,
                        // so it has been stable for a full low half-period.
                        cnt    <= cnt + CNT_W'(1);
                        sclk_q <= 1'b1;
                        rx_sr  <= {rx_sr[5:0], bus.miso};
                        if (rw_q && data_byte_end) begin
                            rdata_q[{byte_num, 3'b000} +: 8] <= {rx_sr, bus.miso};
                            bv_q  <= 1'b1;
                            idx_q <= LEN_W'(byte_num);
                        end
                    end else if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (last_bit) begin
                            mosi_q <= 1'b0;
                        end else begin
                            sclk_q  <= 1'b0;
                            mosi_q  <= tx_sr[FRAME_W-1];
                            tx_sr   <= tx_sr << 1;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        finish_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_MPU_BURST_CS_EN
    logic ncs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ncs_q <= 1'b1;
        end else if (state == IDLE && bus.start) begin
            ncs_q <= 1'b0;
        end else if (state == HOLD && cnt == HOLD_LAST) begin
            ncs_q <= 1'b1;
        end
    end

    assign bus.ncs = ncs_q;
`endif

    assign bus.sclk       = sclk_q;
    assign bus.mosi       = mosi_q;
    assign bus.busy       = busy_q;
    assign bus.finish     = finish_q;
    assign bus.rdata      = rdata_q;
    assign bus.byte_valid = bv_q;
    assign bus.byte_idx   = idx_q;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_spi_mpu_burst.sv
// tb_spi_mpu_burst
// Purpose: self-checking bench for spi_mpu_burst. A driver issues frames and
//   pushes the expected results. A monitor plays the sensor on miso, records
//   mosi, and checks byte strobes and finish pulses against those expectations.
// Build option: define SPI_MPU_BURST_CS_EN to also check ncs.
`timescale 1ns/1ps
module tb_spi_mpu_burst;
    localparam int SH    = 2;
    localparam int HC    = 4;
    localparam int MB    = 14;
    localparam int LEN_W = $clog2(MB + 1);
    localparam int DW    = 8 * MB;
    localparam int FW    = 8 * (MB + 1);

    typedef struct {
        logic [DW-1:0] rdata;
        int            fin_cyc;
        logic [FW-1:0] mosi;
        int            nbits;
        int            nbv;
    } fin_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fin_t                 fin_q[$];
    logic [LEN_W+8-1:0]   exp_q[$];
    logic [FW-1:0]        miso_q[$];
    int                   miso_nb_q[$];

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_mpu_burst_if #(.MAX_BYTES(MB)) bus ();

    spi_mpu_burst #(
        .SCLK_HALF  (SH),
        .HOLD_CYCLES(HC),
        .MAX_BYTES  (MB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    function automatic logic [DW-1:0] rand_bytes();
        logic [DW-1:0] v;
        for (int i = 0; i < MB; i++) v[8*i +: 8] = 8'($urandom);
        return v;
    endfunction

    // Driver: call at a negedge with the DUT idle (or in its finish cycle).
    task automatic send(input logic rw_i, input logic [6:0] a, input logic [LEN_W-1:0] l,
                        input logic [DW-1:0] wd, input logic [DW-1:0] resp);
        int n;
        fin_t f;
        logic [FW-1:0] ms;
        logic [FW-1:0] mi;
        n  = (l == 0) ? 1 : ((int'(l) > MB) ? MB : int'(l));
        ms = FW'({rw_i, a});
        mi = FW'($urandom_range(0, 255));   // sensor output during the command byte is junk
        f.rdata = '0;
        for (int k = 0; k < n; k++) begin
            ms = (ms << 8) | FW'(rw_i ? 8'h00 : wd[8*k +: 8]);
            mi = (mi << 8) | FW'(resp[8*k +: 8]);
            if (rw_i) begin
                f.rdata[8*k +: 8] = resp[8*k +: 8];
                exp_q.push_back({LEN_W'(k), resp[8*k +: 8]});
            end
        end
        f.mosi    = ms;
        f.nbits   = 8 * (n + 1);
        f.nbv     = rw_i ? n : 0;
        f.fin_cyc = cyc + 1 + SH + 16 * SH * (n + 1) + HC;
        miso_q.push_back(mi);
        miso_nb_q.push_back(8 * (n + 1));
        fin_q.push_back(f);
        bus.rw    = rw_i;
        bus.addr  = a;
        bus.len   = l;
        bus.wdata = wd;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("rdata_cleared", bus.rdata, 0);
`ifdef SPI_MPU_BURST_CS_EN
        check("ncs_active", bus.ncs, 0);
`endif
    endtask

    task automatic wait_done(input int bound);
        int t;
        t = 0;
        while (fin_q.size() != 0 && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (fin_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d frames pending expected 0", fin_q.size());
            fin_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_finish(input int bound);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.finish && t < bound);
        if (!bus.finish) begin
            n_checks++;
            n_fail++;
            $display("FAIL finish_timeout: got no finish expected one within %0d cycles", bound);
        end
    endtask

    // Monitor and sensor model.
    logic          prev_sclk = 1'b1;
    logic [FW-1:0] cur_stream = '0;
    int            cur_nb = 0;
    int            fall_idx = 0;
    logic [FW-1:0] mosi_cap = '0;
    int            bv_seen = 0;
    fin_t          fm;
    logic [LEN_W+8-1:0] e;

    initial begin
        bus.miso = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fin_q.delete();
                exp_q.delete();
                miso_q.delete();
                miso_nb_q.delete();
                fall_idx  = 0;
                cur_nb    = 0;
                mosi_cap  = '0;
                bv_seen   = 0;
                prev_sclk = 1'b1;
            end else begin
                if (prev_sclk && !bus.sclk) begin
                    if (fall_idx == 0) begin
                        if (miso_q.size() > 0) begin
                            cur_stream = miso_q.pop_front();
                            cur_nb     = miso_nb_q.pop_front();
                        end else begin
                            cur_stream = '0;
                            cur_nb     = 0;
                        end
                    end
                    if (fall_idx < cur_nb) bus.miso = cur_stream[cur_nb-1-fall_idx];
                    else bus.miso = 1'($urandom);
                    fall_idx++;
                end
                if (!prev_sclk && bus.sclk) mosi_cap = {mosi_cap[FW-2:0], bus.mosi};
                prev_sclk = bus.sclk;

                if (bus.byte_valid) begin
                    bv_seen++;
                    if (exp_q.size() == 0) fail_now("unexpected_byte_valid");
                    else begin
                        e = exp_q.pop_front();
                        check("byte_valid_idx_data",
                              {bus.byte_idx, bus.rdata[8*int'(bus.byte_idx) +: 8]}, e);
                    end
                end

                if (bus.finish) begin
                    if (fin_q.size() == 0) fail_now("unexpected_finish");
                    else begin
                        fm = fin_q.pop_front();
                        check("rdata", bus.rdata, fm.rdata);
                        check("latency", cyc, fm.fin_cyc);
                        check("mosi_stream", mosi_cap, fm.mosi);
                        check("sclk_falls", fall_idx, fm.nbits);
                        check("byte_valid_count", bv_seen, fm.nbv);
                        check("busy_at_finish", bus.busy, 0);
`ifdef SPI_MPU_BURST_CS_EN
                        check("ncs_at_finish", bus.ncs, 1);
`endif
                    end
                    fall_idx = 0;
                    mosi_cap = '0;
                    bv_seen  = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected one");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] r;
        logic [DW-1:0] w;
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = '0;
        bus.len   = '0;
        bus.wdata = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sclk", bus.sclk, 1);
        check("reset_mosi", bus.mosi, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_finish", bus.finish, 0);
        check("reset_byte_valid", bus.byte_valid, 0);
        check("reset_byte_idx", bus.byte_idx, 0);
        check("reset_rdata", bus.rdata, 0);
`ifdef SPI_MPU_BURST_CS_EN
        check("reset_ncs", bus.ncs, 1);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // single-byte read of WHO_AM_I
        r = '0;
        r[7:0] = 8'h71;
        send(1'b1, 7'h75, LEN_W'(1), rand_bytes(), r);
        wait_done(1000);

        // single-byte write
        w = '0;
        w[7:0] = 8'h80;
        send(1'b0, 7'h6B, LEN_W'(1), w, rand_bytes());
        wait_done(1000);

        // full 14-byte burst read
        for (int k = 0; k < MB; k++) r[8*k +: 8] = 8'(k + 1);
        send(1'b1, 7'h3B, LEN_W'(14), '0, r);
        wait_done(1000);

        // length boundaries: 0 acts as 1, 15 is clamped to 14
        send(1'b1, 7'h12, LEN_W'(0), rand_bytes(), rand_bytes());
        wait_done(1000);
        send(1'b0, 7'h23, LEN_W'(15), rand_bytes(), rand_bytes());
        wait_done(1000);
        send(1'b1, 7'h24, LEN_W'(15), rand_bytes(), rand_bytes());
        wait_done(1000);

        // start while busy is ignored; start in the finish cycle runs back-to-back
        send(1'b1, 7'h41, LEN_W'(2), rand_bytes(), rand_bytes());
        repeat (20) @(negedge clk);
        bus.rw    = 1'b0;
        bus.addr  = 7'h55;
        bus.len   = LEN_W'(5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_finish(1000);
        send(1'b0, 7'h1A, LEN_W'(3), rand_bytes(), rand_bytes());
        wait_finish(1000);
        send(1'b1, 7'h1B, LEN_W'(1), rand_bytes(), rand_bytes());
        wait_done(1000);

        // randomized frames
        for (int i = 0; i < 12; i++) begin
            send(1'($urandom), 7'($urandom), LEN_W'($urandom_range(0, 15)), rand_bytes(), rand_bytes());
            wait_done(1000);
        end

        // reset in the middle of a read, after byte 0 has landed in rdata
        r = rand_bytes();
        r[7:0] = 8'hA5;
        send(1'b1, 7'h3B, LEN_W'(14), '0, r);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_sclk", bus.sclk, 1);
        check("midreset_mosi", bus.mosi, 0);
        check("midreset_busy", bus.busy, 0);
        check("midreset_finish", bus.finish, 0);
        check("midreset_rdata", bus.rdata, 0);
`ifdef SPI_MPU_BURST_CS_EN
        check("midreset_ncs", bus.ncs, 1);
`endif
        rst_n = 1'b1;
        repeat (600) @(negedge clk);
        check("after_reset_busy", bus.busy, 0);

        // the block must still work after an abandoned frame
        send(1'b1, 7'h75, LEN_W'(1), '0, rand_bytes());
        wait_done(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
